record_core: RTL and testbench
==============================

RECORD_CORE -- requirements
Module: record_core

Interface
REQ-001: Parameter REC_MAX, default 23'd1048576, is the maximum number of samples per recording.
REQ-002: Parameter FIFO_DEPTH, default 4, is the number of sample buffer entries (power of two, at least 2).
REQ-003: i_clk  in  1  single system clock; all logic is on its rising edge.
REQ-004: i_rst  in  1  asynchronous, active-low reset.
REQ-005: record_start  in  1  one-cycle pulse that begins a recording; honoured only in IDLE.
REQ-006: record_select  in  23  SDRAM base word address, latched on an accepted record_start.
REQ-007: record_pause  in  1  level; high suspends sample acceptance.
REQ-008: record_stop  in  1  pulse that ends the recording.
REQ-009: record_done  out  1  one-cycle pulse when the recording is fully written.
REQ-010: record_length  out  23  number of samples written; valid from the record_done pulse until the next accepted start.
REQ-011: record_write  out  1  SDRAM write request.
REQ-012: record_addr  out  23  SDRAM word address.
REQ-013: record_writedata  out  16  SDRAM write data.
REQ-014: record_write_finished  in  1  one-cycle pulse when the SDRAM write is complete.
REQ-015: record_audio_valid  in  1  audio sample valid.
REQ-016: record_audio_data  in  16  audio sample (signed PCM).
REQ-017: record_audio_ready  out  1  core can accept a sample.

Function
REQ-018: The controller SHALL use the states IDLE, RECORD, PAUSE, DRAIN and DONE.
REQ-019: IDLE -> RECORD on record_start; on entry, base = record_select, write count = 0, accept count = 0, FIFO is emptied.
REQ-020: A sample is accepted on a cycle where record_audio_valid and record_audio_ready are both high, and it is pushed into the FIFO.
REQ-021: record_audio_ready = 1 only in RECORD with FIFO not full, accept count < REC_MAX and record_stop low.
REQ-022: Write side, active in RECORD, PAUSE and DRAIN: when record_write = 0 and the FIFO is non-empty, assert record_write with record_addr = (base + write count) mod 2^23 and record_writedata = FIFO head.
REQ-023: record_write, record_addr and record_writedata SHALL be held stable until record_write_finished.
REQ-024: On record_write_finished: pop the FIFO, increment write count, drive record_write = 0 on the next cycle; a new request may be asserted the cycle after that.
REQ-025: Minimum latency: a sample accepted in cycle N gives record_write = 1 in cycle N+1.
REQ-026: RECORD -> PAUSE while record_pause = 1; PAUSE -> RECORD when record_pause = 0.
REQ-027: In PAUSE, any in-flight write completes and FIFO contents are retained and keep draining.
REQ-028: RECORD or PAUSE -> DRAIN on record_stop, or when accept count reaches REC_MAX; record_stop has priority over record_pause.
REQ-029: DRAIN -> DONE when the FIFO is empty and record_write = 0.
REQ-030: DONE SHALL assert record_done for exactly one cycle, latch record_length = write count, then go to IDLE.
REQ-031: record_start outside IDLE, and record_stop in IDLE or DONE, SHALL be ignored.
REQ-032: A simultaneous push and pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-033: Address wraps modulo 2^23 past 23'h7FFFFF.
REQ-034: A stop in RECORD with an empty FIFO SHALL still go through DRAIN and DONE; record_length = 0 is legal.

Reset
REQ-035: While i_rst = 0: state = IDLE, FIFO empty, counters = 0, and every output = 0 (record_done, record_length, record_write, record_addr, record_writedata, record_audio_ready).
REQ-036: Reset mid-write SHALL drop record_write immediately and discard buffered samples; no record_done is produced.

Structure
REQ-037: The state enum and address/data width constants belong in the shared project package, also used by PlayCore.
REQ-038: The sample buffer is a sub-module, record_fifo (FIFO_DEPTH x 16, full/empty flags, synchronous push/pop, async active-low clear).

Verification
REQ-039: start with select = 23'h000100, 3 samples 16'h1111/2222/3333, 2-cycle SDRAM finish -> writes to 100/101/102 with that data, then stop -> record_done pulse, record_length = 3.
REQ-040: SDRAM finish delayed 20 cycles, valid held high -> ready drops after FIFO_DEPTH+1 accepts; no sample lost or duplicated.
REQ-041: record_pause high for 10 cycles with 2 samples buffered -> ready = 0, both writes complete, recording resumes at the next address after pause falls.
REQ-042: REC_MAX = 4, continuous samples -> exactly 4 accepted and written, record_length = 4, done without record_stop.
REQ-043: select = 23'h7FFFFE, 3 samples -> addresses 7FFFFE, 7FFFFF, 000000.
REQ-044: i_rst low while record_write = 1 -> all outputs 0 in the same cycle; after release, the core is in IDLE and a new start works.

Source files
------------

// File: rtl/record_core_pkg.sv
// Shared definitions for the SDRAM record/play cores: bus widths and the controller state type.
package record_core_pkg;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECORD,
      ST_PAUSE,
      ST_DRAIN,
      ST_DONE
   } core_state_e;

endpackage

// File: rtl/record_fifo.sv
// Sample buffer between the audio input and the SDRAM write port.
module record_fifo
   import record_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W:0]    wr_ptr_q;
   logic [PTR_W:0]    rd_ptr_q;
   logic              do_push;
   logic              do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/record_core.sv
// Audio record controller: buffers incoming samples and writes them to consecutive SDRAM words.
//   state  | meaning
//   IDLE   | waiting for record_start
//   RECORD | accepting samples and writing them out
//   PAUSE  | acceptance suspended, buffered samples keep draining
//   DRAIN  | stopped, flushing remaining samples to SDRAM
//   DONE   | one-cycle record_done with record_length latched
module record_core
   import record_core_pkg::*;
#(
   parameter logic [ADDR_W-1:0] REC_MAX    = 23'd1048576,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              record_start,
   input  logic [ADDR_W-1:0] record_select,
   input  logic              record_pause,
   input  logic              record_stop,
   output logic              record_done,
   output logic [ADDR_W-1:0] record_length,
   output logic              record_write,
   output logic [ADDR_W-1:0] record_addr,
   output logic [DATA_W-1:0] record_writedata,
   input  logic              record_write_finished,
   input  logic              record_audio_valid,
   input  logic [DATA_W-1:0] record_audio_data,
   output logic              record_audio_ready
);

   core_state_e       state_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic [ADDR_W-1:0] acc_cnt_q;
   logic [ADDR_W-1:0] length_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic              done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clr;
   logic [DATA_W-1:0] fifo_head;
   logic              accept;
   logic              issue;
   logic              write_side;
   logic              at_limit;

   assign fifo_clr   = (state_q == ST_IDLE) && record_start;
   assign at_limit   = (acc_cnt_q >= REC_MAX);
   assign write_side = (state_q == ST_RECORD) || (state_q == ST_PAUSE) || (state_q == ST_DRAIN);

   assign record_audio_ready = (state_q == ST_RECORD) && !fifo_full && !at_limit && !record_stop;
   assign accept = record_audio_valid && record_audio_ready;

   // The request register takes the FIFO head when the request is issued, so the buffer holds
   // FIFO_DEPTH samples behind the one in flight; an empty FIFO forwards the incoming sample.
   assign issue     = write_side && !write_q && (!fifo_empty || accept);
   assign fifo_pop  = issue && !fifo_empty;
   assign fifo_push = accept && !(issue && fifo_empty);

   record_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_rst),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (record_audio_data),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         wr_cnt_q  <= '0;
         acc_cnt_q <= '0;
         length_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;

         if (write_q && record_write_finished) begin
            write_q  <= 1'b0;
            wr_cnt_q <= wr_cnt_q + 1'b1;
         end else if (issue) begin
            write_q <= 1'b1;
            addr_q  <= base_q + wr_cnt_q;
            wdata_q <= fifo_empty ? record_audio_data : fifo_head;
         end

         case (state_q)
            ST_IDLE: begin
               if (record_start) begin
                  state_q   <= ST_RECORD;
                  base_q    <= record_select;
                  wr_cnt_q  <= '0;
                  acc_cnt_q <= '0;
               end
            end
            ST_RECORD: begin
               if (record_stop || at_limit) state_q <= ST_DRAIN;
               else if (record_pause)       state_q <= ST_PAUSE;
            end
            ST_PAUSE: begin
               if (record_stop || at_limit) state_q <= ST_DRAIN;
               else if (!record_pause)      state_q <= ST_RECORD;
            end
            ST_DRAIN: begin
               if (fifo_empty && !write_q) begin
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  length_q <= wr_cnt_q;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign record_done      = done_q;
   assign record_length    = length_q;
   assign record_write     = write_q;
   assign record_addr      = addr_q;
   assign record_writedata = wdata_q;

endmodule

// File: tb/tb_record_core.sv
// Bench for record_core: scenario table, hand-written corner sequences and randomized recordings,
// all checked against a sample-queue scoreboard of accepted data and expected word addresses.
module tb_record_core;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, pause = 1'b0, stop = 1'b0, fin = 1'b0, valid = 1'b0;
   logic [22:0] sel = '0;
   logic [15:0] data = '0;
   logic        done, wr, ready;
   logic [22:0] len, addr;
   logic [15:0] wdata;

   logic        s_start = 1'b0, s_pause = 1'b0, s_stop = 1'b0, s_fin = 1'b0, s_valid = 1'b0;
   logic [22:0] s_sel = 23'h000010;
   logic [15:0] s_data = '0;
   logic        s_done, s_wr, s_ready;
   logic [22:0] s_len, s_addr;
   logic [15:0] s_wdata;

   record_core #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .record_start(start), .record_select(sel), .record_pause(pause), .record_stop(stop),
      .record_done(done), .record_length(len),
      .record_write(wr), .record_addr(addr), .record_writedata(wdata),
      .record_write_finished(fin),
      .record_audio_valid(valid), .record_audio_data(data), .record_audio_ready(ready)
   );

   record_core #(.REC_MAX(23'd4), .FIFO_DEPTH(DEPTH)) dut_max4 (
      .i_clk(clk), .i_rst(rst_n),
      .record_start(s_start), .record_select(s_sel), .record_pause(s_pause), .record_stop(s_stop),
      .record_done(s_done), .record_length(s_len),
      .record_write(s_wr), .record_addr(s_addr), .record_writedata(s_wdata),
      .record_write_finished(s_fin),
      .record_audio_valid(s_valid), .record_audio_data(s_data), .record_audio_ready(s_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // SDRAM models: finish pulse 'lat' cycles after the request appears (main), 1 cycle (small).
   int lat = 1;
   int rsp_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (fin) fin = 1'b0;
      else if (wr) begin
         rsp_cnt++;
         if (rsp_cnt >= lat) begin
            fin = 1'b1;
            rsp_cnt = 0;
         end
      end else rsp_cnt = 0;
   end

   always @(posedge clk) begin
      #1;
      s_fin = s_wr && !s_fin;
   end

   // Scoreboard: every accepted sample must be written once, in order, to base + n.
   logic [15:0] exp_q[$];
   logic [22:0] base_m = '0;
   logic [22:0] last_addr = '0;
   logic [22:0] ea;
   int          wr_n = 0, n_acc = 0, done_cnt = 0;
   logic        prev_wr = 1'b0, prev_fin = 1'b0;
   logic [22:0] prev_addr = '0;
   logic [15:0] prev_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_wr = 1'b0;
         prev_fin = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (valid && ready) begin
            exp_q.push_back(data);
            n_acc++;
         end
         if (prev_wr && !prev_fin)
            chk("write_hold", {wr, addr, wdata}, {1'b1, prev_addr, prev_data});
         if (wr && fin) begin
            ea = base_m + wr_n[22:0];
            chk("write_addr", addr, ea);
            chk("write_has_sample", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("write_data", wdata, exp_q.pop_front());
            wr_n++;
            last_addr = addr;
         end
         prev_wr = wr;
         prev_fin = fin;
         prev_addr = addr;
         prev_data = wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_rec(input logic [22:0] s);
      tick();
      start = 1'b1;
      sel = s;
      base_m = s;
      wr_n = 0;
      n_acc = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      bit ok;
      ok = 1'b0;
      valid = 1'b1;
      data = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = ready;
      end
      chk("send_accepted", ok, 1'b1);
      tick();
      valid = 1'b0;
   endtask

   task automatic stop_and_finish(input logic [22:0] exp_len, input string tag);
      bit seen;
      seen = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk({tag, "_done"}, seen, 1'b1);
      chk({tag, "_length"}, len, exp_len);
      chk({tag, "_written"}, wr_n, exp_len);
      chk({tag, "_leftover"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tag, "_done_width"}, {done, len}, {1'b0, exp_len});
      tick();
   endtask

   typedef struct {
      logic [22:0] sel;
      int          n;
      int          lat;
      logic [22:0] last;
      logic [22:0] exp_len;
   } vec_t;
   vec_t vecs[5];

   int          d0, a0, bp, sa, sw, sdone;
   bit          stalled, s_acc;
   logic [22:0] slen, slast;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{23'h000100, 3, 2, 23'h000102, 23'd3};
      vecs[1] = '{23'h7FFFFE, 3, 1, 23'h000000, 23'd3};
      vecs[2] = '{23'h0ABCDE, 0, 1, 23'h0ABCDE, 23'd0};
      vecs[3] = '{23'h123456, 6, 3, 23'h12345B, 23'd6};
      vecs[4] = '{23'h7FFFFF, 2, 4, 23'h000000, 23'd2};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {done, len, wr, addr, wdata, ready}, 128'd0);
      chk("reset_outputs_max4", {s_done, s_len, s_wr, s_addr, s_wdata, s_ready}, 128'd0);
      tick();
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         lat = vecs[v].lat;
         start_rec(vecs[v].sel);
         for (int k = 0; k < vecs[v].n; k++) send(16'h1111 * 16'(k + 1));
         stop_and_finish(vecs[v].exp_len, $sformatf("vec%0d", v));
         if (vecs[v].n > 0) chk($sformatf("vec%0d_last_addr", v), last_addr, vecs[v].last);
      end

      // Minimum latency, start ignored while recording, stop ignored in IDLE.
      lat = 3;
      start_rec(23'h000400);
      send(16'hBEEF);
      @(negedge clk);
      chk("latency_write", {wr, wdata}, {1'b1, 16'hBEEF});
      tick();
      start = 1'b1;
      sel = 23'h555555;
      tick();
      start = 1'b0;
      send(16'hCAFE);
      stop_and_finish(23'd2, "start_ignored");
      chk("start_ignored_last_addr", last_addr, 23'h000401);
      d0 = done_cnt;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (5) tick();
      chk("idle_stop_ignored", {done_cnt, wr}, {d0, 1'b0});

      // Slow SDRAM with valid held high: one sample in flight plus a full buffer.
      lat = 20;
      start_rec(23'h000200);
      valid = 1'b1;
      data = 16'hA000;
      bp = 0;
      stalled = 1'b0;
      for (int i = 0; i < 40 && !stalled; i++) begin
         @(negedge clk);
         if (ready) begin
            bp++;
            tick();
            data = data + 16'd1;
         end else if (bp > 0) stalled = 1'b1;
         else tick();
      end
      chk("backpressure_accepts", bp, DEPTH + 1);
      tick();
      for (int k = 0; k < 3; k++) send(data + 16'(k));
      stop_and_finish(23'd8, "backpressure");

      // Pause with two samples buffered.
      lat = 3;
      start_rec(23'h000300);
      send(16'h0A01);
      send(16'h0A02);
      pause = 1'b1;
      tick();
      valid = 1'b1;
      data = 16'h0BAD;
      a0 = n_acc;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("pause_ready", ready, 1'b0);
         tick();
      end
      chk("pause_no_accept", n_acc, a0);
      chk("pause_writes_done", wr_n, 2);
      valid = 1'b0;
      pause = 1'b0;
      send(16'h0A03);
      stop_and_finish(23'd3, "pause");
      chk("pause_resume_addr", last_addr, 23'h000302);

      // Accept limit of 4 ends the recording without a stop.
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_valid = 1'b1;
      s_data = 16'h4000;
      sa = 0; sw = 0; sdone = 0;
      slen = '0; slast = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         s_acc = s_valid && s_ready;
         if (s_acc) sa++;
         if (s_wr && s_fin) begin
            sw++;
            slast = s_addr;
         end
         if (s_done) begin
            sdone++;
            slen = s_len;
         end
         tick();
         if (s_acc) s_data = s_data + 16'd1;
      end
      s_valid = 1'b0;
      chk("max4_accepts", sa, 4);
      chk("max4_writes", sw, 4);
      chk("max4_done_pulses", sdone, 1);
      chk("max4_length", slen, 23'd4);
      chk("max4_last_addr", slast, 23'h000013);

      // Reset while a write is outstanding.
      lat = 20;
      start_rec(23'h000600);
      send(16'h0601);
      send(16'h0602);
      chk("pre_reset_write", wr, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_write", {done, len, wr, addr, wdata, ready}, 128'd0);
      d0 = done_cnt;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("reset_no_done", {done_cnt, wr}, {d0, 1'b0});
      lat = 1;
      start_rec(23'h000700);
      send(16'h0701);
      stop_and_finish(23'd1, "after_reset");

      // Randomized recordings; stop may arrive with pause high.
      for (int r = 0; r < 3; r++) begin
         lat = 1 + $urandom_range(0, 3);
         start_rec(23'($urandom));
         for (int c = 0; c < 150; c++) begin
            valid = 1'($urandom_range(0, 1));
            data = 16'($urandom);
            pause = ($urandom_range(0, 7) == 0);
            tick();
         end
         valid = 1'b0;
         pause = 1'($urandom_range(0, 1));
         tick();
         stop_and_finish(n_acc[22:0], $sformatf("rand%0d", r));
         pause = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
